// File: rtl/cnn_pkg.sv
// Types and helpers shared by the CNN classifier output-stage blocks.
package cnn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } argmax_state_t;

    // An index into a vector of n elements; a single-element vector still gets 1 bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/argmax_lane_cmp.sv
// One scan beat of argmax: folds up to LANES candidates into the running max/idx in
// ascending index order. Runner-up tracking is included when ARGMAX_TOP2_EN is defined.
module argmax_lane_cmp
    import cnn_pkg::*;
#(
    parameter int LANES       = 2,
    parameter int INPUT_WIDTH = 16,
    parameter int IDX_WIDTH   = 4,
    parameter int SIGNED      = 0
) (
    input  logic [INPUT_WIDTH-1:0]       i_max,
    input  logic [IDX_WIDTH-1:0]         i_idx,
`ifdef ARGMAX_TOP2_EN
    input  logic [INPUT_WIDTH-1:0]       i_max2,
    input  logic [IDX_WIDTH-1:0]         i_idx2,
    input  logic                         i_has2,
`endif
    input  logic [LANES*INPUT_WIDTH-1:0] i_cand,
    input  logic [IDX_WIDTH-1:0]         i_base,
    input  logic [LANES-1:0]             i_mask,
    output logic [INPUT_WIDTH-1:0]       o_max,
    output logic [IDX_WIDTH-1:0]         o_idx
`ifdef ARGMAX_TOP2_EN
    ,
    output logic [INPUT_WIDTH-1:0]       o_max2,
    output logic [IDX_WIDTH-1:0]         o_idx2,
    output logic                         o_has2
`endif
);

    function automatic logic gt(input logic [INPUT_WIDTH-1:0] a,
                                input logic [INPUT_WIDTH-1:0] b);
        if (SIGNED != 0) return $signed(a) > $signed(b);
        return a > b;
    endfunction

    logic [INPUT_WIDTH-1:0] w_v;
    logic [IDX_WIDTH-1:0]   w_ci;

    // Strict greater-than keeps the earliest index on ties.
    always_comb begin
        o_max = i_max;
        o_idx = i_idx;
`ifdef ARGMAX_TOP2_EN
        o_max2 = i_max2;
        o_idx2 = i_idx2;
        o_has2 = i_has2;
`endif
        w_v  = '0;
        w_ci = '0;
        for (int k = 0; k < LANES; k++) begin
            w_v  = i_cand[k*INPUT_WIDTH +: INPUT_WIDTH];
            w_ci = i_base + IDX_WIDTH'(k);
            if (i_mask[k]) begin
                if (gt(w_v, o_max)) begin
`ifdef ARGMAX_TOP2_EN
                    o_max2 = o_max;
                    o_idx2 = o_idx;
                    o_has2 = 1'b1;
`endif
                    o_max = w_v;
                    o_idx = w_ci;
                end
`ifdef ARGMAX_TOP2_EN
                else if (!o_has2 || gt(w_v, o_max2)) begin
                    o_max2 = w_v;
                    o_idx2 = w_ci;
                    o_has2 = 1'b1;
                end
`endif
            end
        end
    end

endmodule

// File: rtl/argmax_stream.sv
// Multi-lane streaming argmax: accepts one NUM_INPUT-element vector per handshake and
// scans it LANES elements per cycle. Define ARGMAX_TOP2_EN to add runner-up outputs.
module argmax_stream
    import cnn_pkg::*;
#(
    parameter int NUM_INPUT    = 10,
    parameter int INPUT_WIDTH  = 16,
    parameter int LANES        = 2,
    parameter int SIGNED       = 0,
    parameter int OPDATA_WIDTH = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_INPUT*INPUT_WIDTH-1:0] ip_data,
    input  logic                             ip_valid,
    output logic                             ip_ready,
    output logic [OPDATA_WIDTH-1:0]          op_data,
    output logic [INPUT_WIDTH-1:0]           op_max,
    output logic                             op_data_valid,
    input  logic                             op_ready
`ifdef ARGMAX_TOP2_EN
    ,
    output logic [OPDATA_WIDTH-1:0]          op_idx2,
    output logic [INPUT_WIDTH-1:0]           op_max2
`endif
);

    localparam int IDX_WIDTH = idx_width(NUM_INPUT);
    localparam int BUF_W     = NUM_INPUT * INPUT_WIDTH;

    argmax_state_t          r_state, w_next;
    logic [BUF_W-1:0]       r_buf;
    logic [IDX_WIDTH-1:0]   r_ptr, r_idx, r_op_idx;
    logic [INPUT_WIDTH-1:0] r_max, r_op_max;
    logic [LANES-1:0]       w_mask;
    logic                   w_last;
    logic [INPUT_WIDTH-1:0] w_max;
    logic [IDX_WIDTH-1:0]   w_idx;
`ifdef ARGMAX_TOP2_EN
    logic [IDX_WIDTH-1:0]   r_idx2, r_op_idx2, w_idx2;
    logic [INPUT_WIDTH-1:0] r_max2, r_op_max2, w_max2;
    logic                   r_has2, w_has2;
`endif

    // Lanes past the end of the vector are masked; the beat reaching NUM_INPUT-1 is the last.
    always_comb begin
        w_mask = '0;
        for (int k = 0; k < LANES; k++)
            w_mask[k] = (int'(r_ptr) + k) < NUM_INPUT;
        w_last = (int'(r_ptr) + LANES) >= NUM_INPUT;
    end

    argmax_lane_cmp #(
        .LANES      (LANES),
        .INPUT_WIDTH(INPUT_WIDTH),
        .IDX_WIDTH  (IDX_WIDTH),
        .SIGNED     (SIGNED)
    ) u_cmp (
        .i_max (r_max),
        .i_idx (r_idx),
`ifdef ARGMAX_TOP2_EN
        .i_max2(r_max2),
        .i_idx2(r_idx2),
        .i_has2(r_has2),
`endif
        .i_cand(r_buf[LANES*INPUT_WIDTH-1:0]),
        .i_base(r_ptr),
        .i_mask(w_mask),
        .o_max (w_max),
        .o_idx (w_idx)
`ifdef ARGMAX_TOP2_EN
        ,
        .o_max2(w_max2),
        .o_idx2(w_idx2),
        .o_has2(w_has2)
`endif
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (ip_valid) w_next = (NUM_INPUT == 1) ? HOLD : SCAN;
            SCAN:    if (w_last) w_next = HOLD;
            HOLD:    if (op_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        ip_ready      = (r_state == IDLE) && !rst;
        op_data_valid = (r_state == HOLD);
    end

    // The buffer shifts down each beat so the current candidates always sit in its low lanes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf    <= '0;
            r_ptr    <= '0;
            r_max    <= '0;
            r_idx    <= '0;
            r_op_max <= '0;
            r_op_idx <= '0;
`ifdef ARGMAX_TOP2_EN
            r_max2    <= '0;
            r_idx2    <= '0;
            r_has2    <= 1'b0;
            r_op_max2 <= '0;
            r_op_idx2 <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: if (ip_valid) begin
                    r_buf <= ip_data >> INPUT_WIDTH;
                    r_max <= ip_data[INPUT_WIDTH-1:0];
                    r_idx <= '0;
                    r_ptr <= IDX_WIDTH'(1);
`ifdef ARGMAX_TOP2_EN
                    r_max2 <= '0;
                    r_idx2 <= '0;
                    r_has2 <= 1'b0;
`endif
                    if (NUM_INPUT == 1) begin
                        r_op_idx <= '0;
                        r_op_max <= ip_data[INPUT_WIDTH-1:0];
`ifdef ARGMAX_TOP2_EN
                        r_op_idx2 <= '0;
                        r_op_max2 <= '0;
`endif
                    end
                end
                SCAN: begin
                    r_buf <= r_buf >> (LANES * INPUT_WIDTH);
                    r_ptr <= r_ptr + IDX_WIDTH'(LANES);
                    r_max <= w_max;
                    r_idx <= w_idx;
`ifdef ARGMAX_TOP2_EN
                    r_max2 <= w_max2;
                    r_idx2 <= w_idx2;
                    r_has2 <= w_has2;
`endif
                    if (w_last) begin
                        r_op_idx <= w_idx;
                        r_op_max <= w_max;
`ifdef ARGMAX_TOP2_EN
                        r_op_idx2 <= w_idx2;
                        r_op_max2 <= w_max2;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign op_data = OPDATA_WIDTH'(r_op_idx);
    assign op_max  = r_op_max;
`ifdef ARGMAX_TOP2_EN
    assign op_idx2 = OPDATA_WIDTH'(r_op_idx2);
    assign op_max2 = r_op_max2;
`endif

endmodule

// File: doc/argmax_stream.md
# argmax_stream

Parametrised multi-lane argmax unit for the CNN classifier output stage. It accepts one vector of NUM_INPUT scores in a single ready/valid beat and scans it LANES elements per cycle. It returns the index of the largest element and that element's value, and holds the result until the consumer takes it. It replaces the single-lane, unsigned, handshake-less max finder.

## Interface
- NUM_INPUT, 10, elements per vector (>=1)
- INPUT_WIDTH, 16, bits per element
- LANES, 2, elements compared per scan cycle (1..NUM_INPUT)
- SIGNED, 0, 1 = elements compared as two's complement, 0 = unsigned
- OPDATA_WIDTH, 32, width of index output; IDX_WIDTH = max(1,$clog2(NUM_INPUT)) is a derived localparam
- clk  input  1  clock; all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- ip_data  input  NUM_INPUT*INPUT_WIDTH  vector; element i at [i*INPUT_WIDTH +: INPUT_WIDTH]
- ip_valid  input  1  vector present
- ip_ready  output  1  unit can accept a vector
- op_data  output  OPDATA_WIDTH  argmax index, zero-extended
- op_max  output  INPUT_WIDTH  value at op_data (raw bits)
- op_data_valid  output  1  result valid; held until op_ready
- op_ready  input  1  consumer takes result

## Operation
- States: IDLE, SCAN, HOLD.
- IDLE: ip_ready=1.
  - On ip_valid: capture ip_data into buffer; max=element 0; idx=0; ptr=1.
  - Go to SCAN, or directly to HOLD when NUM_INPUT==1.
- SCAN: each cycle evaluates elements ptr..ptr+LANES-1 in ascending index order.
  - Elements >= NUM_INPUT are ignored.
  - Replace on strict greater-than only, so ties resolve to the lowest index.
  - ptr += LANES.
  - On the beat covering element NUM_INPUT-1, op_data/op_max are loaded and the state moves to HOLD.
- HOLD: op_data_valid=1; op_data/op_max stable.
  - On op_ready, go to IDLE and clear op_data_valid.
  - op_data/op_max keep their last value.
- ip_ready = (state==IDLE) && !rst. Vectors presented while ip_ready=0 are ignored, not queued.
- Comparison uses $signed when SIGNED=1, otherwise unsigned. Index arithmetic is IDX_WIDTH bits. op_data upper bits are 0.
- Reset (any state, including mid-SCAN or HOLD): next edge gives state=IDLE, op_data=0, op_max=0, op_data_valid=0, buffer/ptr cleared. An in-flight vector is discarded with no output.
- rst has priority over ip_valid and op_ready in the same cycle.

## Timing
- Accepting edge E0 (ip_valid && ip_ready sampled high).
- S = ceil((NUM_INPUT-1)/LANES) scan edges E1..ES.
- op_data_valid is high after edge ES, i.e. S edges after acceptance; for NUM_INPUT==1 it is high after E0.
- Defaults: S=5.
- op_data_valid falls the edge after op_ready is sampled high in HOLD. ip_ready rises in the same cycle.
- Minimum vector-to-vector spacing: S+2 cycles with op_ready held high.
- Critical path: LANES chained compare/select stages. LANES trades throughput against Fmax.

## Configuration
- ARGMAX_TOP2_EN defined: adds outputs op_idx2 (OPDATA_WIDTH) and op_max2 (INPUT_WIDTH), the runner-up (largest element excluding op_data index).
  - Lowest index on ties. A duplicate of the maximum qualifies as runner-up.
  - Update rule per candidate: if v>max, runner-up takes old max/idx; else if runner-up empty or v>runner-up, runner-up takes v.
  - op_idx2/op_max2 reset to 0, are valid with op_data_valid, and are 0 when NUM_INPUT==1.
- Not defined: ports and logic absent; behaviour otherwise identical.

## Structure
- Shared package cnn_pkg holds:
  - argmax_state_t enum {IDLE, SCAN, HOLD}
  - function idx_width(n) returning max(1,$clog2(n))
- Sub-module argmax_lane_cmp (combinational): takes running max/idx (and runner-up under ARGMAX_TOP2_EN), LANES candidates, base index, valid mask and SIGNED; returns updated max/idx. Instantiated once in the SCAN datapath.

## Test plan
- Defaults, elements [3,7,2,9,9,1,0,4,5,8], op_ready=1 -> op_data=3, op_max=9, op_data_valid after 5 edges for 1 cycle, ip_ready back to 1 next cycle.
- All elements 0xFFF0 except element 6=0x0002 -> SIGNED=1: op_data=6, op_max=0x0002; SIGNED=0: op_data=0, op_max=0xFFF0.
- op_ready low 4 cycles in HOLD, second vector driven with ip_valid=1 -> op_data_valid/op_data stable, ip_ready=0, second vector ignored; op_ready high -> valid drops next edge.
- rst pulsed at the 2nd scan edge -> all outputs 0, no op_data_valid; next vector [0,...,0,5] -> op_data=9, op_max=5.
- LANES=3, NUM_INPUT=10, element 9=0x0100, others smaller -> op_data=9 after 3 edges. NUM_INPUT=1, element 0=0x0042 -> op_data=0, op_max=0x0042 valid after E0.
- ARGMAX_TOP2_EN, vector from scenario 1 -> op_data=3, op_idx2=4, op_max2=9. Vector [1,2,3,...,10] -> op_data=9, op_idx2=8, op_max2=9.
